// File: rtl/mem_arbiter.sv
// Two-master arbiter for the shared 8-bit synchronous memory/IO port.
// Registered single-byte accesses with programmable latency, round-robin or fixed priority, bus lock.
module mem_arbiter #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned MEM_LAT   = 1,
  parameter bit          FIXED_PRI = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_read,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [7:0]        m0_wdata,
  output logic [7:0]        m0_rdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_read,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [7:0]        m1_wdata,
  output logic [7:0]        m1_rdata,
  output logic              m1_ack,
  output logic              mem_cs,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din,
  output logic [1:0]        gnt
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                mem_cs_q, mem_cs_d;
  logic                mem_read_q, mem_read_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_dout_q, mem_dout_d;
  logic                m0_ack_q, m0_ack_d;
  logic                m1_ack_q, m1_ack_d;
  logic [7:0]          m0_rdata_q, m0_rdata_d;
  logic [7:0]          m1_rdata_q, m1_rdata_d;
  logic [1:0]          gnt_q, gnt_d;
  logic                last_grant_q, last_grant_d;  // 0 = m0, 1 = m1
  logic                lock_vld_q, lock_vld_d;
  logic                lock_id_q, lock_id_d;
  logic                win_q, win_d;                // owner of the access in flight

  logic owner_lock, locked, elig0, elig1, pick1, win_lock;

  always_comb begin
    owner_lock = lock_id_q ? m1_lock : m0_lock;
    locked     = lock_vld_q && owner_lock;
    elig0      = m0_req && (!locked || !lock_id_q);
    elig1      = m1_req && (!locked || lock_id_q);
    // m1 wins when alone, or on a round-robin tie after an m0 grant.
    pick1      = elig1 && (!elig0 || (!FIXED_PRI && !last_grant_q));
    win_lock   = win_q ? m1_lock : m0_lock;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_cs_d     = mem_cs_q;
    mem_read_d   = mem_read_q;
    mem_addr_d   = mem_addr_q;
    mem_dout_d   = mem_dout_q;
    m0_ack_d     = m0_ack_q;
    m1_ack_d     = m1_ack_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    lock_vld_d   = lock_vld_q;
    lock_id_d    = lock_id_q;
    win_d        = win_q;

    case (state_q)
      StIdle: begin
        mem_cs_d = 1'b0;
        // Owner dropped its lock while the bus sat idle.
        if (lock_vld_q && !owner_lock) begin
          lock_vld_d = 1'b0;
          gnt_d      = 2'b00;
        end
        if (elig0 || elig1) begin
          win_d        = pick1;
          mem_addr_d   = pick1 ? m1_addr : m0_addr;
          mem_read_d   = pick1 ? m1_read : m0_read;
          mem_dout_d   = pick1 ? m1_wdata : m0_wdata;
          mem_cs_d     = 1'b1;
          gnt_d        = pick1 ? 2'b10 : 2'b01;
          last_grant_d = pick1;
          cnt_d        = 4'(MEM_LAT);
          state_d      = StAccess;
        end
      end
      StAccess: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (mem_read_q) begin
            if (win_q) m1_rdata_d = mem_din;
            else       m0_rdata_d = mem_din;
          end
          if (win_q) m1_ack_d = 1'b1;
          else       m0_ack_d = 1'b1;
          mem_cs_d   = 1'b0;
          mem_read_d = 1'b1;
          state_d    = StDone;
        end
      end
      StDone: begin
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;
        lock_vld_d = win_lock;
        lock_id_d  = win_q;
        if (!win_lock) gnt_d = 2'b00;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      mem_cs_q     <= 1'b0;
      mem_read_q   <= 1'b1;
      mem_addr_q   <= '0;
      mem_dout_q   <= 8'h00;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_rdata_q   <= 8'h00;
      m1_rdata_q   <= 8'h00;
      gnt_q        <= 2'b00;
      last_grant_q <= 1'b1;
      lock_vld_q   <= 1'b0;
      lock_id_q    <= 1'b0;
      win_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_cs_q     <= mem_cs_d;
      mem_read_q   <= mem_read_d;
      mem_addr_q   <= mem_addr_d;
      mem_dout_q   <= mem_dout_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      lock_vld_q   <= lock_vld_d;
      lock_id_q    <= lock_id_d;
      win_q        <= win_d;
    end
  end

  assign mem_cs   = mem_cs_q;
  assign mem_read = mem_read_q;
  assign mem_addr = mem_addr_q;
  assign mem_dout = mem_dout_q;
  assign m0_ack   = m0_ack_q;
  assign m1_ack   = m1_ack_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign gnt      = gnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a round-robin instance (MEM_LAT=2) and a fixed-priority
// instance (MEM_LAT=3); expected memory cycles and acks are queued as stimulus is issued.
module tb_mem_arbiter;
  localparam int unsigned LAT0 = 2;
  localparam int unsigned LAT1 = 3;

  typedef struct packed {logic m; logic rd; logic [7:0] data;} ack_t;
  typedef struct packed {logic [15:0] addr; logic rd; logic [7:0] dout; logic [1:0] gnt;} mem_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Round-robin instance
  logic m0_req, m0_read, m0_lock, m1_req, m1_read, m1_lock;
  logic [15:0] m0_addr, m1_addr, mem_addr;
  logic [7:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_dout, mem_din;
  logic m0_ack, m1_ack, mem_cs, mem_read;
  logic [1:0] gnt;
  // Fixed-priority instance
  logic f_m0_req, f_m0_read, f_m0_lock, f_m1_req, f_m1_read, f_m1_lock;
  logic [15:0] f_m0_addr, f_m1_addr, f_mem_addr;
  logic [7:0] f_m0_wdata, f_m1_wdata, f_m0_rdata, f_m1_rdata, f_mem_dout, f_mem_din;
  logic f_m0_ack, f_m1_ack, f_mem_cs, f_mem_read;
  logic [1:0] f_gnt;

  ack_t ack_q0[$], ack_q1[$];
  mem_t mem_q0[$], mem_q1[$];
  int n_vec = 0, n_err = 0;
  int cs_len0 = 0, cs_len1 = 0;
  logic cs_prev0 = 1'b0, cs_prev1 = 1'b0;
  logic [7:0] exp_r0_0 = 8'h00, exp_r1_0 = 8'h00, exp_r0_1 = 8'h00, exp_r1_1 = 8'h00;

  mem_arbiter #(.ADDR_W(16), .MEM_LAT(LAT0), .FIXED_PRI(1'b0)) u_rr (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_read(m0_read), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_read(m1_read), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .mem_cs(mem_cs), .mem_read(mem_read), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din), .gnt(gnt)
  );

  mem_arbiter #(.ADDR_W(16), .MEM_LAT(LAT1), .FIXED_PRI(1'b1)) u_fix (
    .clk(clk), .rst(rst),
    .m0_req(f_m0_req), .m0_read(f_m0_read), .m0_lock(f_m0_lock), .m0_addr(f_m0_addr),
    .m0_wdata(f_m0_wdata), .m0_rdata(f_m0_rdata), .m0_ack(f_m0_ack),
    .m1_req(f_m1_req), .m1_read(f_m1_read), .m1_lock(f_m1_lock), .m1_addr(f_m1_addr),
    .m1_wdata(f_m1_wdata), .m1_rdata(f_m1_rdata), .m1_ack(f_m1_ack),
    .mem_cs(f_mem_cs), .mem_read(f_mem_read), .mem_addr(f_mem_addr), .mem_dout(f_mem_dout),
    .mem_din(f_mem_din), .gnt(f_gnt)
  );

  function automatic logic [7:0] mdata(input logic [15:0] a);
    return (a == 16'h1234) ? 8'hA5 : (a[7:0] ^ a[15:8]);
  endfunction

  // Memory returns real data only on the cycle it is due; any other sample sees 0xEE.
  assign mem_din   = (mem_cs && cs_len0 == int'(LAT0)) ? mdata(mem_addr) : 8'hEE;
  assign f_mem_din = (f_mem_cs && cs_len1 == int'(LAT1)) ? mdata(f_mem_addr) : 8'hEE;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor, round-robin instance
  always @(posedge clk) begin
    ack_t a;
    mem_t e;
    if (!rst) begin
      cs_prev0 = 1'b0; cs_len0 = 0; exp_r0_0 = 8'h00; exp_r1_0 = 8'h00;
    end else begin
      if (m0_ack || m1_ack) begin
        if (ack_q0.size() == 0) begin
          check("rr unexpected ack", 32'({m1_ack, m0_ack}), 32'd0);
        end else begin
          a = ack_q0.pop_front();
          check("rr ack owner", 32'({m1_ack, m0_ack}), a.m ? 32'd2 : 32'd1);
          if (a.rd) begin
            if (a.m) exp_r1_0 = a.data;
            else     exp_r0_0 = a.data;
          end
        end
        check("rr m0_rdata", 32'(m0_rdata), 32'(exp_r0_0));
        check("rr m1_rdata", 32'(m1_rdata), 32'(exp_r1_0));
      end
      if (mem_cs && !cs_prev0) begin
        if (mem_q0.size() == 0) begin
          check("rr unexpected access", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          e = mem_q0.pop_front();
          check("rr mem_addr", 32'(mem_addr), 32'(e.addr));
          check("rr mem_read", 32'(mem_read), 32'(e.rd));
          check("rr mem_dout", 32'(mem_dout), 32'(e.dout));
          check("rr gnt", 32'(gnt), 32'(e.gnt));
        end
        cs_len0 = 1;
      end else if (mem_cs) begin
        cs_len0++;
      end else begin
        if (cs_prev0) check("rr cs length", 32'(cs_len0), 32'(LAT0));
        cs_len0 = 0;
      end
      cs_prev0 = mem_cs;
    end
  end

  // Monitor, fixed-priority instance
  always @(posedge clk) begin
    ack_t a;
    mem_t e;
    if (!rst) begin
      cs_prev1 = 1'b0; cs_len1 = 0; exp_r0_1 = 8'h00; exp_r1_1 = 8'h00;
    end else begin
      if (f_m0_ack || f_m1_ack) begin
        if (ack_q1.size() == 0) begin
          check("fix unexpected ack", 32'({f_m1_ack, f_m0_ack}), 32'd0);
        end else begin
          a = ack_q1.pop_front();
          check("fix ack owner", 32'({f_m1_ack, f_m0_ack}), a.m ? 32'd2 : 32'd1);
          if (a.rd) begin
            if (a.m) exp_r1_1 = a.data;
            else     exp_r0_1 = a.data;
          end
        end
        check("fix m0_rdata", 32'(f_m0_rdata), 32'(exp_r0_1));
        check("fix m1_rdata", 32'(f_m1_rdata), 32'(exp_r1_1));
      end
      if (f_mem_cs && !cs_prev1) begin
        if (mem_q1.size() == 0) begin
          check("fix unexpected access", 32'(f_mem_addr), 32'hFFFF_FFFF);
        end else begin
          e = mem_q1.pop_front();
          check("fix mem_addr", 32'(f_mem_addr), 32'(e.addr));
          check("fix mem_read", 32'(f_mem_read), 32'(e.rd));
          check("fix mem_dout", 32'(f_mem_dout), 32'(e.dout));
          check("fix gnt", 32'(f_gnt), 32'(e.gnt));
        end
        cs_len1 = 1;
      end else if (f_mem_cs) begin
        cs_len1++;
      end else begin
        if (cs_prev1) check("fix cs length", 32'(cs_len1), 32'(LAT1));
        cs_len1 = 0;
      end
      cs_prev1 = f_mem_cs;
    end
  end

  task automatic wait_ack0(input bit m);
    bit ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(posedge clk);
      ok = m ? m1_ack : m0_ack;
    end
    if (!ok) check("rr ack timeout", 32'(m), 32'hFFFF_FFFF);
  endtask

  task automatic wait_ack1(input bit m);
    bit ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(posedge clk);
      ok = m ? f_m1_ack : f_m0_ack;
    end
    if (!ok) check("fix ack timeout", 32'(m), 32'hFFFF_FFFF);
  endtask

  task automatic wait_any0();
    bit ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(posedge clk);
      ok = m0_ack || m1_ack;
    end
    if (!ok) check("rr any-ack timeout", 32'd0, 32'd1);
  endtask

  initial begin
    time t_prev;
    {m0_req, m0_lock, m1_req, m1_lock} = '0;
    {m0_read, m1_read} = 2'b11;
    {m0_addr, m1_addr, m0_wdata, m1_wdata} = '0;
    {f_m0_req, f_m0_lock, f_m1_req, f_m1_lock} = '0;
    {f_m0_read, f_m1_read} = 2'b11;
    {f_m0_addr, f_m1_addr, f_m0_wdata, f_m1_wdata} = '0;

    // Reset values
    repeat (3) @(posedge clk);
    check("rr reset ctl", 32'({mem_cs, mem_read, gnt, m0_ack, m1_ack}), 32'b01_0000);
    check("rr reset addr/dout", 32'({mem_addr, mem_dout}), 32'd0);
    check("rr reset rdata", 32'({m0_rdata, m1_rdata}), 32'd0);
    check("fix reset ctl", 32'({f_mem_cs, f_mem_read, f_gnt, f_m0_ack, f_m1_ack}), 32'b01_0000);
    #2 rst = 1'b1;

    // Reset in the middle of a write on the MEM_LAT=3 instance
    @(posedge clk);
    mem_q1.push_back('{addr: 16'h0042, rd: 1'b0, dout: 8'h77, gnt: 2'b01});
    f_m0_req = 1'b1; f_m0_read = 1'b0; f_m0_addr = 16'h0042; f_m0_wdata = 8'h77;
    for (int i = 0; i < 10 && !f_mem_cs; i++) @(posedge clk);
    check("fix access started", 32'(f_mem_cs), 32'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("fix rst mem_cs", 32'(f_mem_cs), 32'd0);
    check("fix rst mem_read", 32'(f_mem_read), 32'd1);
    check("fix rst gnt/ack", 32'({f_gnt, f_m0_ack}), 32'd0);
    f_m0_req = 1'b0; f_m0_read = 1'b1; f_m0_wdata = 8'h00;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    repeat (4) @(posedge clk);
    check("fix idle after rst", 32'({f_mem_cs, f_gnt}), 32'd0);

    // Single read, m0
    @(posedge clk);
    mem_q0.push_back('{addr: 16'h1234, rd: 1'b1, dout: 8'h00, gnt: 2'b01});
    ack_q0.push_back('{m: 1'b0, rd: 1'b1, data: 8'hA5});
    m0_req = 1'b1; m0_read = 1'b1; m0_addr = 16'h1234;
    wait_ack0(1'b0);
    m0_req = 1'b0;
    repeat (2) @(posedge clk);

    // Write, m1
    mem_q0.push_back('{addr: 16'h00FF, rd: 1'b0, dout: 8'h5A, gnt: 2'b10});
    ack_q0.push_back('{m: 1'b1, rd: 1'b0, data: 8'h00});
    m1_req = 1'b1; m1_read = 1'b0; m1_addr = 16'h00FF; m1_wdata = 8'h5A;
    wait_ack0(1'b1);
    m1_req = 1'b0; m1_read = 1'b1; m1_wdata = 8'h00;
    repeat (2) @(posedge clk);
    check("rr dout held", 32'(mem_dout), 32'h5A);
    check("rr read idle", 32'(mem_read), 32'd1);

    // Round-robin contention: both held for four accesses
    for (int k = 0; k < 2; k++) begin
      mem_q0.push_back('{addr: 16'h0010, rd: 1'b1, dout: 8'h00, gnt: 2'b01});
      mem_q0.push_back('{addr: 16'h0020, rd: 1'b1, dout: 8'h00, gnt: 2'b10});
      ack_q0.push_back('{m: 1'b0, rd: 1'b1, data: 8'h10});
      ack_q0.push_back('{m: 1'b1, rd: 1'b1, data: 8'h20});
    end
    m0_req = 1'b1; m0_addr = 16'h0010;
    m1_req = 1'b1; m1_addr = 16'h0020;
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_any0();
      if (k > 0) check("rr access period", 32'(($time - t_prev) / 10), 32'(LAT0 + 2));
      t_prev = $time;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (2) @(posedge clk);

    // Lock: m0 reads 0x2000 then 0x2001 while m1 waits
    mem_q0.push_back('{addr: 16'h2000, rd: 1'b1, dout: 8'h00, gnt: 2'b01});
    mem_q0.push_back('{addr: 16'h2001, rd: 1'b1, dout: 8'h00, gnt: 2'b01});
    mem_q0.push_back('{addr: 16'h0030, rd: 1'b1, dout: 8'h00, gnt: 2'b10});
    ack_q0.push_back('{m: 1'b0, rd: 1'b1, data: 8'h20});
    ack_q0.push_back('{m: 1'b0, rd: 1'b1, data: 8'h21});
    ack_q0.push_back('{m: 1'b1, rd: 1'b1, data: 8'h30});
    m0_req = 1'b1; m0_lock = 1'b1; m0_addr = 16'h2000;
    m1_req = 1'b1; m1_addr = 16'h0030;
    wait_ack0(1'b0);
    m0_addr = 16'h2001;
    @(posedge clk);
    check("lock gnt between", 32'({mem_cs, gnt}), 32'b001);
    @(posedge clk);
    m0_lock = 1'b0;
    wait_ack0(1'b0);
    m0_req = 1'b0;
    @(posedge clk);
    check("lock released gnt", 32'(gnt), 32'd0);
    wait_ack0(1'b1);
    m1_req = 1'b0;
    repeat (2) @(posedge clk);

    // Early drop: m1 req high for one cycle, inputs change after grant
    mem_q0.push_back('{addr: 16'h0044, rd: 1'b1, dout: 8'h00, gnt: 2'b10});
    ack_q0.push_back('{m: 1'b1, rd: 1'b1, data: 8'h44});
    m1_req = 1'b1; m1_addr = 16'h0044;
    @(posedge clk);
    m1_req = 1'b0; m1_addr = 16'hBEEF;
    wait_ack0(1'b1);
    repeat (8) @(posedge clk);
    check("early drop idle", 32'({mem_cs, gnt}), 32'd0);

    // Fixed priority: m0 wins every tie, m1 starves
    for (int k = 0; k < 3; k++) begin
      mem_q1.push_back('{addr: 16'h0050, rd: 1'b1, dout: 8'h00, gnt: 2'b01});
      ack_q1.push_back('{m: 1'b0, rd: 1'b1, data: 8'h50});
    end
    f_m0_req = 1'b1; f_m0_addr = 16'h0050;
    f_m1_req = 1'b1; f_m1_addr = 16'h0060;
    t_prev = 0;
    for (int k = 0; k < 3; k++) begin
      wait_ack1(1'b0);
      if (k > 0) check("fix access period", 32'(($time - t_prev) / 10), 32'(LAT1 + 2));
      t_prev = $time;
    end
    f_m0_req = 1'b0; f_m1_req = 1'b0;
    repeat (8) @(posedge clk);
    check("fix idle end", 32'({f_mem_cs, f_gnt}), 32'd0);

    check("rr ack queue drained", 32'(ack_q0.size()), 32'd0);
    check("rr mem queue drained", 32'(mem_q0.size()), 32'd0);
    check("fix ack queue drained", 32'(ack_q1.size()), 32'd0);
    check("fix mem queue drained", 32'(mem_q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-master arbiter for the single 8-bit, 16-bit-address memory port of the microcpu system. It shares one synchronous memory/IO port between a CPU-side port (m0) and a DMA/peripheral port (m1) using a req/ack handshake. It supports round-robin or fixed priority and a lock that holds the bus for multi-byte sequences. Each access is a registered single-byte read or write with a programmable memory latency.

Parameters:
ADDR_W, 16, address width of master and memory ports
MEM_LAT, 1, cycles from mem_cs assertion to the mem_din sample edge; legal range 1..15
FIXED_PRI, 0, 0 = round-robin, 1 = m0 always wins ties

Ports:
clk  in  1  clock; all state updates on the falling edge, matching the CPU
rst  in  1  asynchronous, active-low reset
m0_req  in  1  m0 access request; held until m0_ack
m0_read  in  1  1 = read, 0 = write (CPU convention)
m0_lock  in  1  while high, m0 keeps the bus after its ack
m0_addr  in  ADDR_W  m0 address
m0_wdata  in  8  m0 write data
m0_rdata  out  8  m0 read data; valid while m0_ack is high
m0_ack  out  1  one-cycle completion pulse for m0
m1_req, m1_read, m1_lock, m1_addr, m1_wdata, m1_rdata, m1_ack: same as m0, for m1
mem_cs  out  1  memory select; high for exactly MEM_LAT cycles per access
mem_read  out  1  1 = read, 0 = write; write strobe = mem_cs & ~mem_read
mem_addr  out  ADDR_W  registered memory address
mem_dout  out  8  registered write data
mem_din  in  8  memory read data
gnt  out  2  one-hot owner of the current or locked access; 00 when idle

Behaviour:
- Reset (rst low, asynchronous): state IDLE, mem_cs=0, mem_read=1, mem_addr=0, mem_dout=0, m0/m1_ack=0, m0/m1_rdata=0, gnt=00, last_grant=m1 (so m0 wins the first tie), lock_owner=none, cnt=0.
- A reset asserted mid-access abandons the access. No ack is issued, and mem_cs drops immediately.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, at the edge where at least one eligible req is high:
  - pick the winner;
  - latch the winner's addr, read and wdata into mem_addr, mem_read, mem_dout;
  - set mem_cs=1, set gnt, load cnt=MEM_LAT, go to ACCESS.
  - With no eligible req, stay in IDLE; outputs hold and mem_cs=0.
- Eligibility and winner selection:
  - If lock_owner is set, only that master is eligible.
  - Otherwise, a single requester wins.
  - With both requesting: FIXED_PRI=1 picks m0; FIXED_PRI=0 picks the master that is not last_grant.
  - last_grant updates to the winner on every grant.
- ACCESS:
  - cnt decrements each edge.
  - At the edge where cnt==1:
    - for a read, capture mem_din into the winner's rdata;
    - set the winner's ack=1, mem_cs=0, mem_read=1, and go to DONE.
  - The other rdata never changes. For a write, rdata is unchanged.
- DONE:
  - ack is high for this one cycle only.
  - At the next edge: ack=0, go to IDLE.
  - lock_owner = winner if the winner's lock was high at that edge, else none.
  - gnt is cleared unless lock_owner is set.
  - No arbitration happens in DONE. The requester drops req at the same edge it sees ack, so the request is not double-serviced.
- Timing:
  - Grant edge E0; mem_cs high from E0 to E0+MEM_LAT; mem_din sampled at E0+MEM_LAT.
  - ack high from E0+MEM_LAT to E0+MEM_LAT+1.
  - Minimum access period is MEM_LAT+2 cycles.
- req dropped before ack: the access still completes and ack still pulses. The master's inputs are not re-sampled after the grant.
- Lock release:
  - The owner deasserts lock, or lets a DONE pass with lock=0; the bus returns to normal arbitration.
  - While locked, the other master's req waits indefinitely.
- Simultaneous edge events: a new req arriving in ACCESS/DONE is only considered in IDLE.
- No combinational path from any master input to any memory output; all memory outputs are registered.

Test Plan:
- Reset: drive rst low mid-ACCESS (MEM_LAT=3) -> mem_cs=0 and mem_read=1 immediately; no ack; after release, gnt=00 and state IDLE.
- Single read: m0 requests read 0x1234, memory returns 0xA5, MEM_LAT=2 -> mem_cs high for 2 cycles with mem_addr=0x1234; m0_ack for 1 cycle with m0_rdata=0xA5; m1_ack stays 0.
- Write: m1 writes 0x5A to 0x00FF -> mem_read=0, mem_dout=0x5A, mem_cs high MEM_LAT cycles; m1_ack pulses once; m1_rdata unchanged.
- Contention, round-robin: both req held continuously for 4 accesses -> grant order m0,m1,m0,m1, each access MEM_LAT+2 cycles apart. With FIXED_PRI=1 -> m0 every time, m1 starves.
- Lock: m0 sets lock, does two reads (0x2000, 0x2001) while m1 requests -> m1 is not granted until after m0's access that completes with lock=0; gnt stays 01 between the locked accesses.
- Early drop: m1 req high for 1 cycle only -> one full access still occurs and m1_ack pulses once; no second grant follows.
